// File: rtl/prf_multiport_pkg.sv
// Shared types and default sizing for the physical register file and its hookup structs.
package prf_multiport_pkg;

  localparam int NUM_PREGS_DEF = 64;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_RD_DEF    = 6;
  localparam int NUM_WR_DEF    = 3;
  localparam int NUM_ALLOC_DEF = 3;
  localparam int PREG_W_DEF    = $clog2(NUM_PREGS_DEF);

  typedef logic [PREG_W_DEF-1:0] preg_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef struct packed {
    preg_t addr;
  } prf_rd_req_t;

  typedef struct packed {
    data_t data;
    logic  ready;
  } prf_rd_resp_t;

  typedef struct packed {
    logic  en;
    preg_t addr;
    data_t data;
  } prf_wr_req_t;

endpackage

// File: rtl/prf_multiport_if.sv
// Bus between rename/dispatch/writeback (master) and the physical register file (slave).
interface prf_multiport_if import prf_multiport_pkg::*; #(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int NUM_ALLOC = NUM_ALLOC_DEF
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [NUM_RD*PREG_W-1:0]    rd_addr;
  logic [NUM_RD*DATA_W-1:0]    rd_data;
  logic [NUM_RD-1:0]           rd_ready;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*PREG_W-1:0]    wr_addr;
  logic [NUM_WR*DATA_W-1:0]    wr_data;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr;
  logic                        flush;
  logic                        wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_ready, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_ready, wr_conflict
  );

endinterface

// File: rtl/prf_bypass_mux.sv
// Per-read-port forwarding: a same-cycle writeback to the read preg overrides storage,
// highest write port index wins; preg 0 is never forwarded.
module prf_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int NUM_WR = 3
) (
  input  logic [PREG_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*PREG_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ready
);

  always_comb begin
    rd_data  = st_data;
    rd_ready = st_ready;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (rd_addr != '0) && (wr_addr[j*PREG_W +: PREG_W] == rd_addr)) begin
        rd_data  = wr_data[j*DATA_W +: DATA_W];
        rd_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Multiported physical register file with ready-bit scoreboard, write-to-read bypass,
// highest-index write priority and flush recovery of the ready bits.
module prf_multiport import prf_multiport_pkg::*; #(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int NUM_ALLOC = NUM_ALLOC_DEF
) (
  input  logic           clk,
  input  logic           reset,
  prf_multiport_if.slave bus
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [DATA_W-1:0]        mem [NUM_PREGS];
  logic [NUM_PREGS-1:0]     ready;
  logic [DATA_W-1:0]        st_data [NUM_RD];
  logic [NUM_RD-1:0]        st_ready;
  logic [NUM_RD*DATA_W-1:0] rd_data_v;
  logic [NUM_RD-1:0]        rd_ready_v;
  logic [NUM_WR*NUM_WR-1:0] pair_hit;
  logic                     wr_conflict_q;

  // Later loop iterations override earlier ones: higher write ports win, then alloc/flush set ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PREGS; p++) mem[p] <= '0;
      ready <= '1;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*PREG_W +: PREG_W] != '0)) begin
          mem[bus.wr_addr[j*PREG_W +: PREG_W]]   <= bus.wr_data[j*DATA_W +: DATA_W];
          ready[bus.wr_addr[j*PREG_W +: PREG_W]] <= 1'b1;
        end
      end
      if (bus.flush) begin
        ready <= '1;
      end else begin
        for (int k = 0; k < NUM_ALLOC; k++) begin
          if (bus.alloc_en[k] && (bus.alloc_addr[k*PREG_W +: PREG_W] != '0))
            ready[bus.alloc_addr[k*PREG_W +: PREG_W]] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_pi
    for (genvar j = 0; j < NUM_WR; j++) begin : g_pj
      if (j > i) begin : g_hit
        assign pair_hit[i*NUM_WR+j] = bus.wr_en[i] && bus.wr_en[j] &&
          (bus.wr_addr[i*PREG_W +: PREG_W] == bus.wr_addr[j*PREG_W +: PREG_W]) &&
          (bus.wr_addr[i*PREG_W +: PREG_W] != '0);
      end else begin : g_none
        assign pair_hit[i*NUM_WR+j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_conflict_q <= 1'b0;
    else       wr_conflict_q <= |pair_hit;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign st_data[i]  = mem[bus.rd_addr[i*PREG_W +: PREG_W]];
    assign st_ready[i] = ready[bus.rd_addr[i*PREG_W +: PREG_W]];

    prf_bypass_mux #(
      .DATA_W (DATA_W),
      .PREG_W (PREG_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .rd_addr  (bus.rd_addr[i*PREG_W +: PREG_W]),
      .st_data  (st_data[i]),
      .st_ready (st_ready[i]),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_data  (rd_data_v[i*DATA_W +: DATA_W]),
      .rd_ready (rd_ready_v[i])
    );
  end

  assign bus.rd_data     = rd_data_v;
  assign bus.rd_ready    = rd_ready_v;
  assign bus.wr_conflict = wr_conflict_q;

`ifndef SYNTHESIS
  logic reset_q;
  always_ff @(posedge clk) reset_q <= reset;

  a_preg0_zero: assert property (@(posedge clk) mem[0] == '0);
  a_no_conflict_after_reset: assert property (@(posedge clk) reset_q |-> !wr_conflict_q);
`endif

endmodule

// File: tb/tb_prf_multiport.sv
// Directed bench for prf_multiport: default configuration plus a 128-preg/4-read/2-write instance.
module tb_prf_multiport;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prf_multiport_if #(.NUM_PREGS(64), .DATA_W(32), .NUM_RD(6), .NUM_WR(3), .NUM_ALLOC(3)) b ();
  prf_multiport_if #(.NUM_PREGS(128), .DATA_W(32), .NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(3)) b2 ();

  prf_multiport #(.NUM_PREGS(64), .DATA_W(32), .NUM_RD(6), .NUM_WR(3), .NUM_ALLOC(3)) dut (
    .clk(clk), .reset(reset), .bus(b)
  );

  prf_multiport #(.NUM_PREGS(128), .DATA_W(32), .NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(3)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    b.rd_addr = '0;  b.wr_en = '0;  b.wr_addr = '0;  b.wr_data = '0;
    b.alloc_en = '0; b.alloc_addr = '0; b.flush = 1'b0;
    b2.rd_addr = '0;  b2.wr_en = '0;  b2.wr_addr = '0;  b2.wr_data = '0;
    b2.alloc_en = '0; b2.alloc_addr = '0; b2.flush = 1'b0;
  endtask

  task automatic wr(input int port, input logic [5:0] a, input logic [31:0] d);
    b.wr_en[port] = 1'b1;
    b.wr_addr[port*6 +: 6] = a;
    b.wr_data[port*32 +: 32] = d;
  endtask

  task automatic alloc(input int port, input logic [5:0] a);
    b.alloc_en[port] = 1'b1;
    b.alloc_addr[port*6 +: 6] = a;
  endtask

  task automatic rd(input int port, input logic [5:0] a);
    b.rd_addr[port*6 +: 6] = a;
  endtask

  task automatic test_reset();
    clear_in(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    rd(0, 6'd5); rd(1, 6'd63); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h0) begin errors++; $display("FAIL reset_p5_data got %h exp 0", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_p5_ready got %b exp 1", b.rd_ready[0]); end
    checks++; if (b.rd_data[32 +: 32] !== 32'h0) begin errors++; $display("FAIL reset_p63_data got %h exp 0", b.rd_data[32 +: 32]); end
    checks++; if (b.rd_ready[1] !== 1'b1) begin errors++; $display("FAIL reset_p63_ready got %b exp 1", b.rd_ready[1]); end
    checks++; if (b.wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", b.wr_conflict); end
    wr(0, 6'd0, 32'hDEAD); rd(0, 6'd0); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h0) begin errors++; $display("FAIL p0_nobypass got %h exp 0", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL p0_ready got %b exp 1", b.rd_ready[0]); end
    tick(); clear_in(); rd(0, 6'd0); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h0) begin errors++; $display("FAIL p0_stored got %h exp 0", b.rd_data[0 +: 32]); end
  endtask

  task automatic test_alloc_bypass();
    clear_in(); alloc(0, 6'd7); tick();
    clear_in(); rd(0, 6'd7); #1;
    checks++; if (b.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL alloc_p7_ready got %b exp 0", b.rd_ready[0]); end
    wr(1, 6'd7, 32'h1234); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h1234) begin errors++; $display("FAIL bypass_p7_data got %h exp 1234", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL bypass_p7_ready got %b exp 1", b.rd_ready[0]); end
    tick(); clear_in(); rd(0, 6'd7); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h1234) begin errors++; $display("FAIL stored_p7_data got %h exp 1234", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL stored_p7_ready got %b exp 1", b.rd_ready[0]); end
  endtask

  task automatic test_conflict();
    clear_in(); wr(0, 6'd9, 32'hAAAA); wr(2, 6'd9, 32'hBBBB); rd(2, 6'd9); #1;
    checks++; if (b.rd_data[64 +: 32] !== 32'hBBBB) begin errors++; $display("FAIL conflict_bypass got %h exp bbbb", b.rd_data[64 +: 32]); end
    tick(); clear_in(); rd(0, 6'd9); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'hBBBB) begin errors++; $display("FAIL conflict_stored got %h exp bbbb", b.rd_data[0 +: 32]); end
    checks++; if (b.wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse got %b exp 1", b.wr_conflict); end
    tick();
    checks++; if (b.wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear got %b exp 0", b.wr_conflict); end
  endtask

  task automatic test_distinct();
    clear_in(); wr(0, 6'd11, 32'h1); wr(1, 6'd12, 32'h2); wr(2, 6'd13, 32'h3);
    rd(0, 6'd11); rd(1, 6'd12); rd(2, 6'd13); #1;
    checks++; if (b.rd_data[95:0] !== {32'h3, 32'h2, 32'h1}) begin errors++; $display("FAIL distinct_bypass got %h exp 000000030000000200000001", b.rd_data[95:0]); end
    tick(); clear_in(); rd(0, 6'd11); rd(1, 6'd12); rd(2, 6'd13);
    wr(0, 6'd0, 32'h5); wr(1, 6'd0, 32'h6); #1;
    checks++; if (b.wr_conflict !== 1'b0) begin errors++; $display("FAIL distinct_conflict got %b exp 0", b.wr_conflict); end
    checks++; if (b.rd_data[95:0] !== {32'h3, 32'h2, 32'h1}) begin errors++; $display("FAIL distinct_stored got %h exp 000000030000000200000001", b.rd_data[95:0]); end
    tick();
    checks++; if (b.wr_conflict !== 1'b0) begin errors++; $display("FAIL p0_conflict got %b exp 0", b.wr_conflict); end
  endtask

  task automatic test_flush();
    clear_in(); alloc(0, 6'd3); alloc(1, 6'd4); alloc(2, 6'd5); tick();
    clear_in(); rd(0, 6'd3); rd(1, 6'd4); rd(2, 6'd5); rd(3, 6'd6); #1;
    checks++; if (b.rd_ready[3:0] !== 4'b1000) begin errors++; $display("FAIL alloc3_ready got %b exp 1000", b.rd_ready[3:0]); end
    b.flush = 1'b1; alloc(0, 6'd6); #1;
    checks++; if (b.rd_ready[3:0] !== 4'b1000) begin errors++; $display("FAIL flush_comb_ready got %b exp 1000", b.rd_ready[3:0]); end
    tick(); b.flush = 1'b0; b.alloc_en = '0; #1;
    checks++; if (b.rd_ready[3:0] !== 4'b1111) begin errors++; $display("FAIL flush_ready got %b exp 1111", b.rd_ready[3:0]); end
  endtask

  task automatic test_alloc_write();
    clear_in(); alloc(1, 6'd10); wr(0, 6'd10, 32'h55); rd(0, 6'd10); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h55) begin errors++; $display("FAIL aw_bypass_data got %h exp 55", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL aw_bypass_ready got %b exp 1", b.rd_ready[0]); end
    tick(); clear_in(); rd(0, 6'd10); #1;
    checks++; if (b.rd_data[0 +: 32] !== 32'h55) begin errors++; $display("FAIL aw_stored_data got %h exp 55", b.rd_data[0 +: 32]); end
    checks++; if (b.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL aw_stored_ready got %b exp 0", b.rd_ready[0]); end
  endtask

  task automatic test_reset_mid();
    clear_in(); wr(0, 6'd20, 32'h77); tick();
    clear_in(); wr(0, 6'd21, 32'h21); wr(1, 6'd23, 32'h1); wr(2, 6'd23, 32'h2);
    alloc(0, 6'd22); alloc(1, 6'd24); b.flush = 1'b1; reset = 1'b1; tick();
    reset = 1'b0; clear_in();
    rd(0, 6'd20); rd(1, 6'd21); rd(2, 6'd23); rd(3, 6'd22); rd(4, 6'd7); rd(5, 6'd10); #1;
    checks++; if (b.rd_data !== '0) begin errors++; $display("FAIL midreset_data got %h exp 0", b.rd_data); end
    checks++; if (b.rd_ready !== 6'b111111) begin errors++; $display("FAIL midreset_ready got %b exp 111111", b.rd_ready); end
    checks++; if (b.wr_conflict !== 1'b0) begin errors++; $display("FAIL midreset_conflict got %b exp 0", b.wr_conflict); end
  endtask

  task automatic test_cfg2();
    clear_in();
    b2.wr_en = 2'b11; b2.wr_addr = {7'd127, 7'd127}; b2.wr_data = {32'hCAFE, 32'h1111};
    b2.rd_addr[21 +: 7] = 7'd127; #1;
    checks++; if (b2.rd_data[96 +: 32] !== 32'hCAFE) begin errors++; $display("FAIL cfg2_bypass got %h exp cafe", b2.rd_data[96 +: 32]); end
    checks++; if (b2.rd_ready[3] !== 1'b1) begin errors++; $display("FAIL cfg2_bypass_ready got %b exp 1", b2.rd_ready[3]); end
    tick(); clear_in(); b2.rd_addr[21 +: 7] = 7'd127;
    b2.alloc_en[2] = 1'b1; b2.alloc_addr[14 +: 7] = 7'd100; #1;
    checks++; if (b2.rd_data[96 +: 32] !== 32'hCAFE) begin errors++; $display("FAIL cfg2_stored got %h exp cafe", b2.rd_data[96 +: 32]); end
    checks++; if (b2.wr_conflict !== 1'b1) begin errors++; $display("FAIL cfg2_conflict got %b exp 1", b2.wr_conflict); end
    tick(); clear_in(); b2.rd_addr[0 +: 7] = 7'd100; #1;
    checks++; if (b2.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL cfg2_alloc_ready got %b exp 0", b2.rd_ready[0]); end
    checks++; if (b2.wr_conflict !== 1'b0) begin errors++; $display("FAIL cfg2_conflict_clear got %b exp 0", b2.wr_conflict); end
    reset = 1'b1; tick(); reset = 1'b0; b2.rd_addr[7 +: 7] = 7'd127; #1;
    checks++; if (b2.rd_data[32 +: 32] !== 32'h0) begin errors++; $display("FAIL cfg2_reset_data got %h exp 0", b2.rd_data[32 +: 32]); end
    checks++; if (b2.rd_ready[1:0] !== 2'b11) begin errors++; $display("FAIL cfg2_reset_ready got %b exp 11", b2.rd_ready[1:0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    test_reset();
    test_alloc_bypass();
    test_conflict();
    test_distinct();
    test_flush();
    test_alloc_write();
    test_reset_mid();
    test_cfg2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
